// File: rtl/wtile_shift_pkg.sv
// Shared constants, state/source encodings and width helpers for the
// weight-tile shift block.
package wtile_pkg;

  localparam int NCH_D = 16;
  localparam int DW_D  = 8;
  localparam int AW_D  = 4;
  localparam int KW_D  = 3;
  localparam int OW_D  = 19;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  // Where a lane takes its next weight from.
  typedef enum logic [1:0] {SRC_MEM, SRC_LEFT, SRC_UP, SRC_HOME} src_t;

  // Counter width for a modulo-n count; never narrower than one bit.
  function automatic int cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Bit width of one channel slice in the flattened weight buses.
  function automatic int ch_bits(input int dw);
    return dw;
  endfunction

endpackage

// File: rtl/wtile_shift_if.sv
// Control, memory and neighbour-weight bundle of one weight tile.
interface wtile_shift_if import wtile_pkg::*; #(
  parameter int NCH = NCH_D,
  parameter int DW  = DW_D,
  parameter int AW  = AW_D,
  parameter int KW  = KW_D,
  parameter int OW  = OW_D
) ();

  logic                     start;
  logic                     en;
  logic [AW-1:0]            base_addr;
  logic [AW-1:0]            raddr;
  logic [NCH-1:0][DW-1:0]   rdata;
  logic [NCH-1:0][DW-1:0]   left_in;
  logic [NCH-1:0][DW-1:0]   up_in;
  logic [NCH-1:0][DW-1:0]   home_in;
  logic [NCH-1:0][DW-1:0]   w_q;
  logic [cw(KW)-1:0]        x;
  logic [cw(KW)-1:0]        y;
  logic [cw(OW)-1:0]        X;
  logic [cw(OW)-1:0]        Y;
  logic                     busy;
  logic                     finish;

  modport master (
    output start, en, base_addr, rdata, left_in, up_in, home_in,
    input  raddr, w_q, x, y, X, Y, busy, finish
  );

  modport slave (
    input  start, en, base_addr, rdata, left_in, up_in, home_in,
    output raddr, w_q, x, y, X, Y, busy, finish
  );

endinterface

// File: rtl/wtile_shift_count.sv
// Modulo-(MAX+1) counter; wrap flags the terminal value so outer
// counters can chain on it.
module count_mod import wtile_pkg::*; #(
  parameter int MAX = 2,
  localparam int W  = cw(MAX + 1)
) (
  input  logic         clk,
  input  logic         xrst,
  input  logic         enable,
  output logic [W-1:0] q,
  output logic         wrap
);

  assign wrap = (q == W'(MAX));

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst)       q <= '0;
    else if (enable) q <= wrap ? '0 : q + W'(1);
  end

endmodule

// File: rtl/wtile_shift_lane.sv
// One channel's weight register; pure bit-exact selection, no arithmetic.
module wtile_shift_lane import wtile_pkg::*; #(
  parameter int DW = DW_D
) (
  input  logic          clk,
  input  logic          xrst,
  input  logic          cap,
  input  src_t          sel,
  input  logic [DW-1:0] rd,
  input  logic [DW-1:0] left,
  input  logic [DW-1:0] up,
  input  logic [DW-1:0] home,
  output logic [DW-1:0] q
);

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) q <= '0;
    else if (cap) begin
      case (sel)
        SRC_MEM:  q <= rd;
        SRC_LEFT: q <= left;
        SRC_UP:   q <= up;
        SRC_HOME: q <= home;
        default:  q <= left;
      endcase
    end
  end

endmodule

// File: rtl/wtile_shift.sv
// Weight tile: loads kernel weights from memory, then shifts weights in
// from neighbour tiles while stepping x/y/X/Y kernel and output counters.
module wtile_shift import wtile_pkg::*; #(
  parameter int NCH = NCH_D,
  parameter int DW  = DW_D,
  parameter int AW  = AW_D,
  parameter int KW  = KW_D,
  parameter int OW  = OW_D
) (
  input  logic          clk,
  input  logic          xrst,
  wtile_shift_if.slave  bus
);

  state_t                 state, state_nx;
  src_t                   sel;
  logic                   cap, take_addr, fin;
  logic                   step, last;
  logic                   wx, wy, wX, wY;
  logic [AW-1:0]          raddr_q;
  logic [NCH-1:0][DW-1:0] wq;

  assign step = (state == RUN) && bus.en;
  assign last = wx && wy && wX && wY;

  // Counters need no explicit clear: they reset to 0 and wrap back to 0
  // on the terminal step, so every run starts from 0.
  count_mod #(.MAX(KW-1)) u_x (.clk, .xrst, .enable(step),
                               .q(bus.x), .wrap(wx));
  count_mod #(.MAX(KW-1)) u_y (.clk, .xrst, .enable(step && wx),
                               .q(bus.y), .wrap(wy));
  count_mod #(.MAX(OW-1)) u_X (.clk, .xrst, .enable(step && wx && wy),
                               .q(bus.X), .wrap(wX));
  count_mod #(.MAX(OW-1)) u_Y (.clk, .xrst, .enable(step && wx && wy && wX),
                               .q(bus.Y), .wrap(wY));

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cap       = 1'b0;
    sel       = SRC_LEFT;
    take_addr = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_nx  = LOAD;
          take_addr = 1'b1;
        end
      end
      LOAD: begin
        state_nx = RUN;
        cap      = 1'b1;
        sel      = SRC_MEM;
      end
      RUN: begin
        if (step) begin
          cap = 1'b1;
          if (!wx)      sel = SRC_LEFT;
          else if (!wy) sel = SRC_UP;
          else          sel = SRC_HOME;
          if (last) begin
            fin      = 1'b1;
            state_nx = DONE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // raddr is issued as LOAD is entered, so memory data lands on LOAD->RUN.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst)          raddr_q <= '0;
    else if (take_addr) raddr_q <= bus.base_addr;
  end

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    wtile_shift_lane #(.DW(DW)) u_lane (
      .clk, .xrst, .cap, .sel,
      .rd   (bus.rdata[c]),
      .left (bus.left_in[c]),
      .up   (bus.up_in[c]),
      .home (bus.home_in[c]),
      .q    (wq[c])
    );
  end

  assign bus.w_q    = wq;
  assign bus.raddr  = raddr_q;
  assign bus.busy   = (state == LOAD) || (state == RUN);
  assign bus.finish = fin;

endmodule

// File: tb/tb_wtile_shift.sv
// Directed bench for wtile_shift: default geometry plus a small
// NCH=4/KW=5/OW=7 instance.
module tb_wtile_shift;
  import wtile_pkg::*;

  localparam int NCH = 16, DW = 8, AW = 4, KW = 3, OW = 19;
  localparam int PNCH = 4, PKW = 5, POW = 7;

  typedef logic [NCH-1:0][DW-1:0]  vec_t;
  typedef logic [PNCH-1:0][DW-1:0] pvec_t;

  logic clk = 1'b0;
  logic xrst = 1'b0;
  always #5 clk = ~clk;

  wtile_shift_if #(.NCH(NCH), .DW(DW), .AW(AW), .KW(KW), .OW(OW)) bus ();
  wtile_shift_if #(.NCH(PNCH), .DW(DW), .AW(AW), .KW(PKW), .OW(POW)) pbus ();

  wtile_shift #(.NCH(NCH), .DW(DW), .AW(AW), .KW(KW), .OW(OW)) dut (
    .clk(clk), .xrst(xrst), .bus(bus.slave));
  wtile_shift #(.NCH(PNCH), .DW(DW), .AW(AW), .KW(PKW), .OW(POW)) pdut (
    .clk(clk), .xrst(xrst), .bus(pbus.slave));

  int checks = 0;
  int failures = 0;
  vec_t  RD, LF, UP, HM;
  pvec_t PRD, PLF, PUP, PHM;

  task automatic test_reset();
    bus.start = 0; bus.en = 0; bus.base_addr = '0;
    pbus.start = 0; pbus.en = 0; pbus.base_addr = '0;
    xrst = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.w_q !== '0) begin failures++; $display("FAIL reset_wq got=%h exp=0", bus.w_q); end
    checks++; if ({bus.x, bus.y, bus.X, bus.Y} !== '0) begin failures++;
      $display("FAIL reset_cnt got=%h exp=0", {bus.x, bus.y, bus.X, bus.Y}); end
    checks++; if (bus.raddr !== '0) begin failures++; $display("FAIL reset_raddr got=%h exp=0", bus.raddr); end
    checks++; if ({bus.busy, bus.finish} !== 2'b00) begin failures++;
      $display("FAIL reset_flags got=%b exp=00", {bus.busy, bus.finish}); end
    @(negedge clk); xrst = 1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_wait busy got=%b exp=0", bus.busy); end
  endtask

  // Leaves the DUT in RUN cycle 0 of a run with en=1.
  task automatic test_load();
    @(negedge clk); bus.en = 1; bus.base_addr = 4'd5; bus.start = 1; #1;
    @(negedge clk); bus.start = 0; #1;
    checks++; if (bus.raddr !== 4'd5) begin failures++; $display("FAIL load_raddr got=%0d exp=5", bus.raddr); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL load_busy got=%b exp=1", bus.busy); end
    @(negedge clk); #1;
    checks++; if (bus.w_q[0] !== 8'hFD) begin failures++; $display("FAIL load_ch0 got=%h exp=fd", bus.w_q[0]); end
    checks++; if (bus.w_q !== RD) begin failures++; $display("FAIL load_all got=%h exp=%h", bus.w_q, RD); end
  endtask

  task automatic test_sequence();
    int seq [9] = '{0, 0, 1, 0, 0, 1, 0, 0, 2};
    int n = 1;
    bit seen = 0;
    vec_t e;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk); #1; n++;
      e = (seq[k-1] == 0) ? LF : (seq[k-1] == 1) ? UP : HM;
      checks++; if (bus.w_q !== e) begin failures++;
        $display("FAIL seq_src step=%0d got=%h exp=%h", k, bus.w_q, e); end
    end
    checks++; if ({bus.x, bus.y, bus.X} !== {2'd0, 2'd0, 5'd1}) begin failures++;
      $display("FAIL seq_cnt got x=%0d y=%0d X=%0d exp 0 0 1", bus.x, bus.y, bus.X); end
    while (n < 10000) begin
      @(negedge clk); #1; n++;
      if (bus.finish) begin seen = 1; break; end
    end
    checks++; if (!seen || n != 3249) begin failures++;
      $display("FAIL run_len got=%0d exp=3249 seen=%0d", n, seen); end
    checks++; if ({bus.x, bus.y, bus.X, bus.Y} !== {2'd2, 2'd2, 5'd18, 5'd18}) begin failures++;
      $display("FAIL term_cnt got %0d %0d %0d %0d", bus.x, bus.y, bus.X, bus.Y); end
    @(negedge clk); #1;
    checks++; if ({bus.finish, bus.busy} !== 2'b00 || {bus.x, bus.y, bus.X, bus.Y} !== '0) begin failures++;
      $display("FAIL done_state fin=%b busy=%b cnt=%h exp 0 0 0", bus.finish, bus.busy,
               {bus.x, bus.y, bus.X, bus.Y}); end
    @(negedge clk); #1;
    checks++; if (bus.finish !== 1'b0) begin failures++; $display("FAIL finish_once got=%b exp=0", bus.finish); end
  endtask

  task automatic test_en_toggle();
    int n = 0;
    bit seen = 0, bad = 0;
    @(negedge clk); bus.start = 1; bus.en = 0; #1;
    @(negedge clk); bus.start = 0; #1;
    for (int c = 0; c < 14000; c++) begin
      @(negedge clk); bus.en = c[0]; #1; n++;
      if (c >= 1 && c <= 6) begin
        checks++; if (bus.x !== 2'((c / 2) % 3)) begin failures++;
          $display("FAIL tog_x c=%0d got=%0d exp=%0d", c, bus.x, (c / 2) % 3); end
      end
      if (c == 1) begin
        checks++; if (bus.w_q !== RD) begin failures++; $display("FAIL tog_hold got=%h exp=%h", bus.w_q, RD); end
      end
      if (!bus.en && bus.finish) bad = 1;
      if (bus.finish) begin seen = 1; break; end
    end
    checks++; if (!seen || n != 6498) begin failures++;
      $display("FAIL tog_len got=%0d exp=6498 seen=%0d", n, seen); end
    checks++; if (bad) begin failures++; $display("FAIL tog_fin_en0 got=1 exp=0"); end
    @(negedge clk); bus.en = 1; #1;
  endtask

  task automatic test_start_restart_reset();
    int n = 0;
    bit seen = 0, hit = 0;
    @(negedge clk); bus.start = 1; bus.base_addr = 4'd5; bus.en = 1; #1;
    @(negedge clk); bus.start = 0; #1;
    @(negedge clk); #1; n = 1;
    while (bus.X != 5'd7 && n < 200) begin @(negedge clk); #1; n++; end
    @(negedge clk); bus.base_addr = 4'd11; bus.start = 1; #1; n++;
    @(negedge clk); bus.start = 0; #1; n++;
    checks++; if (bus.busy !== 1'b1 || bus.raddr !== 4'd5) begin failures++;
      $display("FAIL run_start busy=%b raddr=%0d exp 1 5", bus.busy, bus.raddr); end
    while (n < 10000) begin
      @(negedge clk); #1; n++;
      if (bus.finish) begin seen = 1; break; end
    end
    checks++; if (!seen || n != 3249) begin failures++;
      $display("FAIL ign_len got=%0d exp=3249 seen=%0d", n, seen); end
    @(negedge clk); bus.base_addr = 4'd9; bus.start = 1; #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL done_busy got=%b exp=0", bus.busy); end
    @(negedge clk); bus.start = 0; #1;
    checks++; if (bus.busy !== 1'b1 || bus.raddr !== 4'd9) begin failures++;
      $display("FAIL restart busy=%b raddr=%0d exp 1 9", bus.busy, bus.raddr); end
    @(negedge clk); #1; n = 1;
    checks++; if (bus.w_q !== RD) begin failures++; $display("FAIL restart_wq got=%h exp=%h", bus.w_q, RD); end
    while (n < 5000) begin
      if (bus.Y == 5'd10 && bus.X == 5'd4) begin hit = 1; break; end
      @(negedge clk); #1; n++;
    end
    checks++; if (!hit) begin failures++; $display("FAIL reach_y10 got=timeout exp=Y10X4"); end
    #1 xrst = 0;
    #1;
    checks++; if (bus.w_q !== '0 || {bus.x, bus.y, bus.X, bus.Y} !== '0 || bus.raddr !== '0) begin failures++;
      $display("FAIL async_rst wq=%h cnt=%h raddr=%h exp 0", bus.w_q, {bus.x, bus.y, bus.X, bus.Y}, bus.raddr); end
    checks++; if ({bus.busy, bus.finish} !== 2'b00) begin failures++;
      $display("FAIL async_flags got=%b exp=00", {bus.busy, bus.finish}); end
    @(negedge clk); xrst = 1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.x !== 2'd0) begin failures++;
      $display("FAIL post_rst busy=%b x=%0d exp 0 0", bus.busy, bus.x); end
  endtask

  task automatic test_param();
    int n;
    bit seen = 0;
    @(negedge clk); pbus.en = 1; pbus.base_addr = 4'd3; pbus.start = 1; #1;
    @(negedge clk); pbus.start = 0; #1;
    checks++; if (pbus.raddr !== 4'd3) begin failures++; $display("FAIL p_raddr got=%0d exp=3", pbus.raddr); end
    @(negedge clk); #1; n = 1;
    checks++; if (pbus.w_q !== PRD) begin failures++; $display("FAIL p_load got=%h exp=%h", pbus.w_q, PRD); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #1; n++;
      checks++; if (pbus.w_q !== ((k == 5) ? PUP : PLF)) begin failures++;
        $display("FAIL p_src k=%0d got=%h exp=%h", k, pbus.w_q, (k == 5) ? PUP : PLF); end
    end
    while (n < 3000) begin
      @(negedge clk); #1; n++;
      if (pbus.finish) begin seen = 1; break; end
    end
    checks++; if (!seen || n != 1225) begin failures++;
      $display("FAIL p_len got=%0d exp=1225 seen=%0d", n, seen); end
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) begin
      RD[c] = (c == 0) ? 8'hFD : 8'(8'h10 + c);
      LF[c] = 8'(8'h80 + c);
      UP[c] = 8'(8'h40 + c);
      HM[c] = 8'(8'hC0 + c);
    end
    for (int c = 0; c < PNCH; c++) begin
      PRD[c] = 8'(8'hF0 + c);
      PLF[c] = 8'(16 * (c + 1) + c);
      PUP[c] = 8'(8'h85 + 16 * c);
      PHM[c] = 8'(8'h0A + c);
    end
    bus.rdata = RD; bus.left_in = LF; bus.up_in = UP; bus.home_in = HM;
    pbus.rdata = PRD; pbus.left_in = PLF; pbus.up_in = PUP; pbus.home_in = PHM;
    test_reset();
    test_load();
    test_sequence();
    test_en_toggle();
    test_start_restart_reset();
    test_param();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
